// File: rtl/block_alu_acc_seq.sv
// block_alu_acc_seq: ALU/accumulator with an internal shift-add multiply and
// restoring-divide sequencer. The accumulator is {acc_high, acc_low}.
// acc_high holds the ALU result or remainder. acc_low holds the operand or quotient.
//
// Ports:
//   clk_i           rising-edge clock
//   reset_ni        synchronous active-low reset
//   start_i         launch op_i (sampled only while not busy)
//   op_i            000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 MUL, 101 DIV, 110 SHL, 111 SHR
//   bus_data_i      operand A / LOAD source
//   bus_reg_data_i  operand B, latched at an accepted start
//   busy_o          multi-cycle op in progress
//   done_o          one-cycle completion pulse
//   acc_data_o      {acc_high, acc_low}
//   zero_flag_o     acc_data_o == 0
//   sign_flag_o     acc_data_o MSB
//   carry_flag_o    registered carry / borrow / shifted-out bit
//   div_by_zero_o   sticky divide-by-zero, cleared by the next accepted start
//
// Build option: define ALU_ACC_DIV_EN to compile in the divider. When it is
// undefined, op 101 is a single-cycle NOP and div_by_zero_o is tied low.
module block_alu_acc_seq #(
    parameter int unsigned DATA_W = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     bus_data_i,
    input  logic [DATA_W-1:0]     bus_reg_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   acc_data_o,
    output logic                  zero_flag_o,
    output logic                  sign_flag_o,
    output logic                  carry_flag_o,
    output logic                  div_by_zero_o
);

    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned CntW  = $clog2(DATA_W + 1);

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpAnd  = 3'b011;
    localparam logic [2:0] OpMul  = 3'b100;
    localparam logic [2:0] OpDiv  = 3'b101;
    localparam logic [2:0] OpShl  = 3'b110;
    localparam logic [2:0] OpShr  = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                carry_q, carry_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;

    // Multiply step: optional add, then shift {c, acc_high, acc_low} right by one.
    logic [DATA_W:0]     mul_sum;
    logic [ACC_W:0]      mul_cat;
    logic                last_iter;

    assign mul_sum   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, b_q}) : {1'b0, acc_hi_q};
    assign mul_cat   = {mul_sum, acc_lo_q};
    assign last_iter = (cnt_q == CntW'(DATA_W - 1));

`ifdef ALU_ACC_DIV_EN
    // Divide step: shift left into a DATA_W+1 bit partial remainder, then trial subtract.
    logic [DATA_W:0]     div_part;
    logic [DATA_W:0]     div_diff;
    logic [DATA_W-1:0]   div_lo_sh;

    assign div_part  = {acc_hi_q, acc_lo_q[DATA_W-1]};
    assign div_diff  = div_part - {1'b0, b_q};
    assign div_lo_sh = {acc_lo_q[DATA_W-2:0], 1'b0};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    done_d = 1'b1;
                    dbz_d  = 1'b0;
                    unique case (op_i)
                        OpLoad: begin
                            acc_hi_d = '0;
                            acc_lo_d = bus_data_i;
                            carry_d  = 1'b0;
                        end
                        OpAdd: {carry_d, acc_hi_d} = {1'b0, acc_hi_q} + {1'b0, bus_reg_data_i};
                        OpSub: begin
                            acc_hi_d = acc_hi_q - bus_reg_data_i;
                            carry_d  = (acc_hi_q < bus_reg_data_i);
                        end
                        OpAnd: acc_hi_d = acc_hi_q & bus_reg_data_i;
                        OpMul: begin
                            b_d      = bus_reg_data_i;
                            acc_hi_d = '0;
                            cnt_d    = '0;
                            state_d  = StMul;
                            done_d   = 1'b0;
                        end
                        OpDiv: begin
`ifdef ALU_ACC_DIV_EN
                            if (bus_reg_data_i == '0) begin
                                dbz_d = 1'b1;
                            end else begin
                                b_d     = bus_reg_data_i;
                                cnt_d   = '0;
                                state_d = StDiv;
                                done_d  = 1'b0;
                            end
`endif
                        end
                        OpShl: {carry_d, acc_hi_d, acc_lo_d} = {acc_hi_q, acc_lo_q, 1'b0};
                        OpShr: {acc_hi_d, acc_lo_d, carry_d} = {1'b0, acc_hi_q, acc_lo_q};
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_hi_d = mul_cat[ACC_W:DATA_W+1];
                acc_lo_d = mul_cat[DATA_W:1];
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    carry_d = 1'b0;
                end
            end
`ifdef ALU_ACC_DIV_EN
            StDiv: begin
                if (div_part >= {1'b0, b_q}) begin
                    acc_hi_d = div_diff[DATA_W-1:0];
                    acc_lo_d = div_lo_sh | DATA_W'(1);
                end else begin
                    acc_hi_d = div_part[DATA_W-1:0];
                    acc_lo_d = div_lo_sh;
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    carry_d = 1'b0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign acc_data_o    = {acc_hi_q, acc_lo_q};
    assign zero_flag_o   = (acc_data_o == '0);
    assign sign_flag_o   = acc_hi_q[DATA_W-1];
    assign carry_flag_o  = carry_q;
`ifdef ALU_ACC_DIV_EN
    assign div_by_zero_o = dbz_q;
`else
    assign div_by_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_block_alu_acc_seq.sv
// Directed testbench for block_alu_acc_seq with DATA_W=4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_block_alu_acc_seq;

    localparam int unsigned W = 4;

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpAnd  = 3'b011;
    localparam logic [2:0] OpMul  = 3'b100;
    localparam logic [2:0] OpDiv  = 3'b101;
    localparam logic [2:0] OpShl  = 3'b110;
    localparam logic [2:0] OpShr  = 3'b111;

    logic           clk_i = 1'b0;
    logic           reset_ni;
    logic           start_i;
    logic [2:0]     op_i;
    logic [W-1:0]   bus_data_i;
    logic [W-1:0]   bus_reg_data_i;
    logic           busy_o;
    logic           done_o;
    logic [2*W-1:0] acc_data_o;
    logic           zero_flag_o;
    logic           sign_flag_o;
    logic           carry_flag_o;
    logic           div_by_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    block_alu_acc_seq #(.DATA_W(W)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .op_i           (op_i),
        .bus_data_i     (bus_data_i),
        .bus_reg_data_i (bus_reg_data_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .acc_data_o     (acc_data_o),
        .zero_flag_o    (zero_flag_o),
        .sign_flag_o    (sign_flag_o),
        .carry_flag_o   (carry_flag_o),
        .div_by_zero_o  (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_i        = 1'b1;
        op_i           = op;
        bus_data_i     = a;
        bus_reg_data_i = b;
        @(negedge clk_i);
        start_i        = 1'b0;
    endtask

    // Single-cycle op: done next cycle, busy stays low.
    task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [7:0] exp_acc, input logic exp_c);
        issue(op, a, b);
        check({tag, ".done"}, done_o, 1);
        check({tag, ".busy"}, busy_o, 0);
        check({tag, ".acc"}, acc_data_o, exp_acc);
        check({tag, ".carry"}, carry_flag_o, exp_c);
    endtask

    // Wait for done after a multi-cycle issue; reports busy-cycle count and overlap.
    task automatic wait_done(input string tag, input int exp_busy);
        int busy_cycles = 0;
        int overlap     = 0;
        for (int i = 0; i < 20 && !done_o; i++) begin
            if (busy_o) busy_cycles++;
            @(negedge clk_i);
        end
        if (busy_o && done_o) overlap++;
        check({tag, ".done"}, done_o, 1);
        check({tag, ".busy_cycles"}, busy_cycles, exp_busy);
        check({tag, ".busy_done_overlap"}, overlap, 0);
    endtask

    initial begin
        int done_seen;
        reset_ni       = 1'b0;
        start_i        = 1'b0;
        op_i           = OpLoad;
        bus_data_i     = '0;
        bus_reg_data_i = '0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;

        // Reset state
        check("rst.acc", acc_data_o, 8'h00);
        check("rst.zero", zero_flag_o, 1);
        check("rst.sign", sign_flag_o, 0);
        check("rst.carry", carry_flag_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);
        check("rst.dbz", div_by_zero_o, 0);

        // ALU and flags
        single("load_f", OpLoad, 4'hF, 4'h0, 8'h0F, 0);
        single("add_f", OpAdd, 4'h0, 4'hF, 8'hFF, 0);
        check("add_f.sign", sign_flag_o, 1);
        single("add_1", OpAdd, 4'h0, 4'h1, 8'h0F, 1);
        single("sub_1", OpSub, 4'h0, 4'h1, 8'hFF, 1);  // 0 - 1 borrows
        single("and_0", OpAnd, 4'h0, 4'h0, 8'h0F, 1);  // carry untouched by AND
        check("and_0.sign", sign_flag_o, 0);
        single("shl", OpShl, 4'h0, 4'h0, 8'h1E, 0);
        single("shr", OpShr, 4'h0, 4'h0, 8'h0F, 0);
        single("shr2", OpShr, 4'h0, 4'h0, 8'h07, 1);
        @(negedge clk_i);
        check("idle.done_drops", done_o, 0);

        // MUL 0xB * 0x5 = 0x37
        single("mload", OpLoad, 4'hB, 4'h0, 8'h0B, 0);
        issue(OpMul, 4'h0, 4'h5);
        wait_done("mul_b5", 4);
        check("mul_b5.acc", acc_data_o, 8'h37);
        check("mul_b5.carry", carry_flag_o, 0);
        check("mul_b5.sign", sign_flag_o, 0);
        @(negedge clk_i);
        check("mul_b5.done_one", done_o, 0);

        // MUL 0xF * 0xF = 0xE1 (exercises the carry out of the add)
        single("mload2", OpLoad, 4'hF, 4'h0, 8'h0F, 0);
        issue(OpMul, 4'h0, 4'hF);
        wait_done("mul_ff", 4);
        check("mul_ff.acc", acc_data_o, 8'hE1);
        check("mul_ff.sign", sign_flag_o, 1);

        // Back-to-back: LOAD issued in the MUL done cycle
        single("b2b_load", OpLoad, 4'h3, 4'h0, 8'h03, 0);

        // Start during busy is ignored
        single("iload", OpLoad, 4'hB, 4'h0, 8'h0B, 0);
        issue(OpMul, 4'h0, 4'h5);
        @(negedge clk_i);
        issue(OpLoad, 4'h3, 4'h9);
        wait_done("mul_ign", 2);
        check("mul_ign.acc", acc_data_o, 8'h37);

        // Reset mid-MUL aborts without done
        @(negedge clk_i);
        single("aload", OpLoad, 4'hB, 4'h0, 8'h0B, 0);
        issue(OpMul, 4'h0, 4'h5);
        @(negedge clk_i);
        reset_ni = 1'b0;
        @(negedge clk_i);
        check("abort.acc", acc_data_o, 8'h00);
        check("abort.busy", busy_o, 0);
        check("abort.done", done_o, 0);
        reset_ni  = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (done_o) done_seen++;
        end
        check("abort.no_done", done_seen, 0);

`ifdef ALU_ACC_DIV_EN
        // DIV 0xB / 0x5 -> rem 1, quot 2
        single("dload", OpLoad, 4'hB, 4'h0, 8'h0B, 0);
        issue(OpDiv, 4'h0, 4'h5);
        wait_done("div_b5", 4);
        check("div_b5.acc", acc_data_o, 8'h12);
        check("div_b5.dbz", div_by_zero_o, 0);
        @(negedge clk_i);
        single("div0", OpDiv, 4'h0, 4'h0, 8'h12, 0);
        check("div0.dbz", div_by_zero_o, 1);
        single("div0_clr", OpLoad, 4'h1, 4'h0, 8'h01, 0);
        check("div0_clr.dbz", div_by_zero_o, 0);
`else
        single("nload", OpLoad, 4'hB, 4'h0, 8'h0B, 0);
        single("div_nop", OpDiv, 4'h0, 4'h5, 8'h0B, 0);
        check("div_nop.dbz", div_by_zero_o, 0);
        single("div_nop0", OpDiv, 4'h0, 4'h0, 8'h0B, 0);
        check("div_nop0.dbz", div_by_zero_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
